parity_serial_tx: RTL and testbench

PARITY_SERIAL_TX -- requirements
Module: parity_serial_tx

---
 rtl/parity_tx_pkg.sv | 16 +
 rtl/bit_tick_counter.sv | 28 ++
 rtl/parity_serial_tx.sv | 130 +++++++++++++
 tb/tb_parity_serial_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types and line levels for the parity serial transmitter.
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Down-counter producing a one-cycle strobe on the last cycle of each serial bit.
module bit_tick_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic tick_o
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reloads itself on expiry, so every bit after the first is timed without an explicit load.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (load_i || cnt_q == '0) cnt_d = RELOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/parity_serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, parity bit, stop bit.
// Define PARITY_TX_TWO_STOP_EN to send two stop bits.
module parity_serial_tx
    import parity_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             parity_type,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             tick;
    logic             idle;

    assign idle = (state_q == IDLE);

    bit_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (idle),
        .tick_o (tick)
    );

`ifdef PARITY_TX_TWO_STOP_EN
    logic stop2_q, stop2_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        par_d   = par_q;
        done    = 1'b0;
`ifdef PARITY_TX_TWO_STOP_EN
        stop2_d = stop2_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = data_in;
                    par_d   = (^data_in) ^ parity_type;
                    idx_d   = '0;
                    state_d = START;
`ifdef PARITY_TX_TWO_STOP_EN
                    stop2_d = 1'b0;
`endif
                end
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: begin
                if (tick) begin
`ifdef PARITY_TX_TWO_STOP_EN
                    if (!stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
`else
                    done    = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx_q lines up with state_q.
        case (state_d)
            START:   tx_d = LINE_START;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = LINE_STOP;
            default: tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
`ifdef PARITY_TX_TWO_STOP_EN
            stop2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
`ifdef PARITY_TX_TWO_STOP_EN
            stop2_q <= stop2_d;
`endif
        end
    end

    assign tx_out   = tx_q;
    assign in_ready = idle;
    assign busy     = !idle;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Table-driven bench with a frame scoreboard for parity_serial_tx (WIDTH=8, CLKS_PER_BIT=4).
module tb_parity_serial_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef PARITY_TX_TWO_STOP_EN
    localparam int STOP_CYC = 2 * CPB;
`else
    localparam int STOP_CYC = CPB;
`endif
    localparam int FRAME_CYC = 10 * CPB + STOP_CYC;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         parity_type = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready, tx_out, busy, done;

    parity_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .parity_type (parity_type),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         pt;
        logic         par;   // expected parity bit, worked out by hand
        int           act;   // 0 none, 1 hold valid and chain next word, 2 mid-frame poke
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         par;
    } exp_t;

    localparam int NV = 7;
    vec_t v[NV];
    exp_t sb[$];
    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input bit ok, input string name, input string detail);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic par);
        exp_t e;
        e.data = d;
        e.par  = par;
        sb.push_back(e);
    endtask

    task automatic send(input logic [W-1:0] d, input logic pt, input logic par);
        @(negedge clk);
        data_in = d; parity_type = pt; in_valid = 1'b1;
        chk(in_ready === 1'b1, "ready", $sformatf("in_ready got %b want 1", in_ready));
        push(d, par);
        @(posedge clk);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk(tx_out === 1'b1 && in_ready === 1'b1 && busy === 1'b0 && done === 1'b0, name,
            $sformatf("tx/rdy/busy/done got %b%b%b%b want 1110", tx_out, in_ready, busy, done));
    endtask

    task automatic check_frame(input int act, input logic [W-1:0] nd, input logic npt);
        exp_t e;
        logic bits[11];
        int ncyc, cyc, done_at;
        bit ok;
        string detail;
        if (sb.size() == 0) begin
            chk(1'b0, "sb_empty", "no expected frame queued, want 1");
            return;
        end
        e = sb.pop_front();
        bits[0] = 1'b0;
        for (int k = 0; k < W; k++) bits[k+1] = e.data[k];
        bits[9]  = e.par;
        bits[10] = 1'b1;
        cyc = 0; done_at = 0;
        for (int b = 0; b < 11; b++) begin
            ncyc = (b == 10) ? STOP_CYC : CPB;
            ok = 1'b1; detail = "";
            for (int c = 0; c < ncyc; c++) begin
                @(negedge clk);
                cyc++;
                if (b == 0 && c == 0) in_valid = (act == 1);
                if (act == 1 && b == 4 && c == 0) begin data_in = nd; parity_type = npt; end
                if (act == 2 && b == 4) begin data_in = 8'hFF; in_valid = (c == 1); end
                if (done === 1'b1 && done_at == 0) done_at = cyc;
                if (ok && (tx_out !== bits[b] || busy !== 1'b1 || in_ready !== 1'b0 ||
                           done !== (b == 10 && c == ncyc - 1))) begin
                    ok = 1'b0;
                    detail = $sformatf("data %h cyc %0d tx/busy/rdy/done got %b%b%b%b want %b10%b",
                                       e.data, c, tx_out, busy, in_ready, done, bits[b],
                                       (b == 10 && c == ncyc - 1));
                end
            end
            chk(ok, $sformatf("bit%0d", b), detail);
        end
        chk(done_at == FRAME_CYC, "done_at",
            $sformatf("data %h done at cycle %0d want %0d", e.data, done_at, FRAME_CYC));
    endtask

    initial begin
        int hold_cnt;
        bit chained;
        exp_t junk;

        v[0] = '{8'hAA, 1'b0, 1'b0, 0};
        v[1] = '{8'hE0, 1'b0, 1'b1, 0};
        v[2] = '{8'hE0, 1'b1, 1'b0, 0};
        v[3] = '{8'h0F, 1'b0, 1'b0, 2};
        v[4] = '{8'h55, 1'b0, 1'b0, 1};
        v[5] = '{8'hA3, 1'b0, 1'b0, 0};
        v[6] = '{8'hFF, 1'b1, 1'b1, 0};

        #12;
        chk(tx_out === 1'b1 && in_ready === 1'b1 && busy === 1'b0 && done === 1'b0, "reset",
            $sformatf("tx/rdy/busy/done got %b%b%b%b want 1110", tx_out, in_ready, busy, done));
        @(negedge clk);
        rst_n = 1'b1;

        chained = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (!chained) send(v[i].data, v[i].pt, v[i].par);
            check_frame(v[i].act, (i + 1 < NV) ? v[i+1].data : '0, (i + 1 < NV) ? v[i+1].pt : 1'b0);
            check_idle("idle_gap");
            chained = 1'b0;
            if (v[i].act == 1 && i + 1 < NV) begin
                push(v[i+1].data, v[i+1].par);
                chained = 1'b1;
            end
            if (v[i].act == 2) begin
                hold_cnt = 0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    if (busy !== 1'b0) hold_cnt++;
                end
                chk(hold_cnt == 0, "no_accept", $sformatf("busy cycles got %0d want 0", hold_cnt));
            end
        end

        // Abort in the middle of the parity bit.
        send(8'h3C, 1'b1, 1'b1);
        in_valid = 1'b0;
        hold_cnt = 0;
        for (int c = 0; c < 38; c++) @(negedge clk);
        chk(tx_out === 1'b1, "pre_abort_par", $sformatf("tx got %b want 1", tx_out));
        rst_n = 1'b0;
        #1;
        chk(tx_out === 1'b1 && in_ready === 1'b1 && busy === 1'b0 && done === 1'b0, "abort",
            $sformatf("tx/rdy/busy/done got %b%b%b%b want 1110", tx_out, in_ready, busy, done));
        if (sb.size() > 0) junk = sb.pop_front();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done !== 1'b0) hold_cnt++;
        end
        chk(hold_cnt == 0, "abort_no_done", $sformatf("done cycles got %0d want 0", hold_cnt));

        // Word presented together with reset release is taken on the first edge.
        @(negedge clk);
        rst_n = 1'b1; data_in = 8'h01; parity_type = 1'b0; in_valid = 1'b1;
        push(8'h01, 1'b1);
        @(posedge clk);
        check_frame(0, '0, 1'b0);
        check_idle("idle_after_reset");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
